mem_req_arbiter: RTL and testbench

//  Two-client round-robin request arbiter sitting directly upstream of the SRAM controller
//  in mem_mgr. Typical clients: client 0 = rasterizer write path, client 1 = scanout read path.

---
 rtl/mem_req_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Two-client round-robin arbiter serialising single-word requests onto the SRAM controller
// valid/write/done handshake, with a per-transaction timeout and a sticky error flag.
module mem_req_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 22,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_WIDTH      = 5
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iReq0,
  input  logic                  iReq1,
  input  logic                  iWrite0,
  input  logic                  iWrite1,
  input  logic [ADDR_WIDTH-1:0] iAddr0,
  input  logic [ADDR_WIDTH-1:0] iAddr1,
  input  logic [DATA_WIDTH-1:0] iData0,
  input  logic [DATA_WIDTH-1:0] iData1,
  output logic                  oAck0,
  output logic                  oAck1,
  output logic                  oDone0,
  output logic                  oDone1,
  output logic [DATA_WIDTH-1:0] oRdData0,
  output logic [DATA_WIDTH-1:0] oRdData1,
  output logic [ADDR_WIDTH-1:0] oMemAddress,
  output logic [DATA_WIDTH-1:0] oMemData,
  output logic                  oMemWrite,
  output logic                  oMemValidRequest,
  input  logic [DATA_WIDTH-1:0] iMemData,
  input  logic                  iMemValidRead,
  output logic                  oTimeoutErr
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic                  owner_q, owner_d;
  logic                  ack0_q, ack0_d, ack1_q, ack1_d;
  logic                  done0_q, done0_d, done1_q, done1_d;
  logic [DATA_WIDTH-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [DATA_WIDTH-1:0] mdata_q, mdata_d;
  logic                  mwrite_q, mwrite_d;
  logic                  mvalid_q, mvalid_d;
  logic                  err_q, err_d;
  logic                  grant1_c;

  // Tie goes to the client that was not granted last.
  assign grant1_c = iReq1 & (~iReq0 | ~last_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    owner_d  = owner_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rd0_d    = rd0_q;
    rd1_d    = rd1_q;
    maddr_d  = maddr_q;
    mdata_d  = mdata_q;
    mwrite_d = mwrite_q;
    mvalid_d = mvalid_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (iReq0 || iReq1) begin
          last_d   = grant1_c;
          owner_d  = grant1_c;
          maddr_d  = grant1_c ? iAddr1  : iAddr0;
          mdata_d  = grant1_c ? iData1  : iData0;
          mwrite_d = grant1_c ? iWrite1 : iWrite0;
          mvalid_d = 1'b1;
          ack0_d   = ~grant1_c;
          ack1_d   = grant1_c;
          cnt_d    = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (iMemValidRead) begin
          mvalid_d = 1'b0;
          if (!mwrite_q) begin
            if (owner_q) rd1_d = iMemData;
            else         rd0_d = iMemData;
          end
          done0_d = ~owner_q;
          done1_d = owner_q;
          state_d = ST_RECOVER;
        end else if (cnt_q == CNT_LAST) begin
          mvalid_d = 1'b0;
          err_d    = 1'b1;
          done0_d  = ~owner_q;
          done1_d  = owner_q;
          state_d  = ST_RECOVER;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (!iReset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rd0_q    <= '0;
      rd1_q    <= '0;
      maddr_q  <= '0;
      mdata_q  <= '0;
      mwrite_q <= 1'b0;
      mvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
      maddr_q  <= maddr_d;
      mdata_q  <= mdata_d;
      mwrite_q <= mwrite_d;
      mvalid_q <= mvalid_d;
      err_q    <= err_d;
    end
  end

  assign oAck0            = ack0_q;
  assign oAck1            = ack1_q;
  assign oDone0           = done0_q;
  assign oDone1           = done1_q;
  assign oRdData0         = rd0_q;
  assign oRdData1         = rd1_q;
  assign oMemAddress      = maddr_q;
  assign oMemData         = mdata_q;
  assign oMemWrite        = mwrite_q;
  assign oMemValidRequest = mvalid_q;
  assign oTimeoutErr      = err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with an SRAM stub.
module tb_mem_req_arbiter;

  localparam int TIMEOUT = 16;

  logic        iClock, iReset;
  logic        iReq0, iReq1, iWrite0, iWrite1;
  logic [21:0] iAddr0, iAddr1;
  logic [15:0] iData0, iData1;
  logic        oAck0, oAck1, oDone0, oDone1;
  logic [15:0] oRdData0, oRdData1;
  logic [21:0] oMemAddress;
  logic [15:0] oMemData;
  logic        oMemWrite, oMemValidRequest;
  logic [15:0] iMemData;
  logic        iMemValidRead;
  logic        oTimeoutErr;

  mem_req_arbiter dut (
    .iClock(iClock), .iReset(iReset),
    .iReq0(iReq0), .iReq1(iReq1), .iWrite0(iWrite0), .iWrite1(iWrite1),
    .iAddr0(iAddr0), .iAddr1(iAddr1), .iData0(iData0), .iData1(iData1),
    .oAck0(oAck0), .oAck1(oAck1), .oDone0(oDone0), .oDone1(oDone1),
    .oRdData0(oRdData0), .oRdData1(oRdData1),
    .oMemAddress(oMemAddress), .oMemData(oMemData), .oMemWrite(oMemWrite),
    .oMemValidRequest(oMemValidRequest),
    .iMemData(iMemData), .iMemValidRead(iMemValidRead),
    .oTimeoutErr(oTimeoutErr)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 transaction outstanding, 2 recovery gap.
  int          m_phase, m_ptr, m_owner, m_busy_cycles;
  logic        m_ack [2];
  logic        m_done [2];
  logic [15:0] m_rd [2];
  logic [21:0] m_addr;
  logic [15:0] m_data;
  logic        m_write, m_valid, m_err;

  // SRAM stub controls
  logic [15:0] sram [16];
  int          stub_wait, stub_delay_max;
  logic        stub_never, stray_en, force_mvr, prev_valid;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_step();
    int w;
    if (!iReset) begin
      m_phase = 0; m_ptr = 1; m_owner = 0; m_busy_cycles = 0;
      m_ack[0] = 0; m_ack[1] = 0; m_done[0] = 0; m_done[1] = 0;
      m_rd[0] = '0; m_rd[1] = '0;
      m_addr = '0; m_data = '0; m_write = 0; m_valid = 0; m_err = 0;
    end else begin
      m_ack[0] = 0; m_ack[1] = 0; m_done[0] = 0; m_done[1] = 0;
      case (m_phase)
        0: if (iReq0 || iReq1) begin
          if (iReq0 && iReq1) w = 1 - m_ptr;
          else                w = iReq1 ? 1 : 0;
          m_ptr = w; m_owner = w;
          m_addr  = (w == 1) ? iAddr1  : iAddr0;
          m_data  = (w == 1) ? iData1  : iData0;
          m_write = (w == 1) ? iWrite1 : iWrite0;
          m_valid = 1; m_ack[w] = 1; m_busy_cycles = 0; m_phase = 1;
        end
        1: begin
          m_busy_cycles++;
          if (iMemValidRead) begin
            if (!m_write) m_rd[m_owner] = iMemData;
            m_valid = 0; m_done[m_owner] = 1; m_phase = 2;
          end else if (m_busy_cycles == TIMEOUT) begin
            m_valid = 0; m_err = 1; m_done[m_owner] = 1; m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic compare_all();
    chk("ack0",   32'(oAck0),            32'(m_ack[0]));
    chk("ack1",   32'(oAck1),            32'(m_ack[1]));
    chk("done0",  32'(oDone0),           32'(m_done[0]));
    chk("done1",  32'(oDone1),           32'(m_done[1]));
    chk("rd0",    32'(oRdData0),         32'(m_rd[0]));
    chk("rd1",    32'(oRdData1),         32'(m_rd[1]));
    chk("maddr",  32'(oMemAddress),      32'(m_addr));
    chk("mdata",  32'(oMemData),         32'(m_data));
    chk("mwrite", 32'(oMemWrite),        32'(m_write));
    chk("mvalid", 32'(oMemValidRequest), 32'(m_valid));
    chk("err",    32'(oTimeoutErr),      32'(m_err));
  endtask

  task automatic stub_update();
    if (oMemValidRequest && !prev_valid) stub_wait = $urandom_range(0, stub_delay_max);
    if (force_mvr) begin
      iMemValidRead = 1'b1;
      iMemData      = 16'($urandom);
    end else if (oMemValidRequest && !stub_never) begin
      if (stub_wait == 0) begin
        iMemValidRead = 1'b1;
        if (oMemWrite) begin
          sram[oMemAddress[3:0]] = oMemData;
          iMemData = 16'($urandom);
        end else begin
          iMemData = sram[oMemAddress[3:0]];
        end
      end else begin
        stub_wait--;
        iMemValidRead = 1'b0;
      end
    end else if (!oMemValidRequest && stray_en) begin
      iMemValidRead = 1'($urandom_range(0, 1));
      iMemData      = 16'($urandom);
    end else begin
      iMemValidRead = 1'b0;
    end
    prev_valid = oMemValidRequest;
  endtask

  // One clock: model follows the edge, outputs compared and stub driven on the falling edge.
  task automatic cycle();
    @(posedge iClock);
    model_step();
    @(negedge iClock);
    compare_all();
    stub_update();
  endtask

  task automatic set_req(input int c, input logic wr, input logic [21:0] a, input logic [15:0] d);
    if (c == 0) begin iReq0 = 1; iWrite0 = wr; iAddr0 = a; iData0 = d; end
    else        begin iReq1 = 1; iWrite1 = wr; iAddr1 = a; iData1 = d; end
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_zero_pulses"}, 32'({oAck0, oAck1, oDone0, oDone1}), 32'd0);
    chk({tag, "_zero_rd"},     32'({oRdData0, oRdData1}), 32'd0);
    chk({tag, "_zero_mem"},    32'({oMemAddress, oMemWrite, oMemValidRequest}), 32'd0);
    chk({tag, "_zero_mdata"},  32'(oMemData), 32'd0);
    chk({tag, "_zero_err"},    32'(oTimeoutErr), 32'd0);
  endtask

  initial begin
    int n;
    logic [15:0] saved_rd0, saved_rd1;
    iReset = 0; iReq0 = 0; iReq1 = 0; iWrite0 = 0; iWrite1 = 0;
    iAddr0 = '0; iAddr1 = '0; iData0 = '0; iData1 = '0;
    iMemData = '0; iMemValidRead = 0;
    stub_wait = 0; stub_delay_max = 0; stub_never = 0; stray_en = 0; force_mvr = 0;
    prev_valid = 0;
    for (int i = 0; i < 16; i++) sram[i] = '0;

    repeat (3) cycle();
    chk_all_zero("reset");
    iReset = 1;
    cycle();

    // Client 0 writes 0xBEEF to 0x00010
    set_req(0, 1, 22'h00010, 16'hBEEF);
    cycle();
    iReq0 = 0;
    chk("t1_ack0",  32'({oAck0, oAck1}), 32'b10);
    chk("t1_mem",   32'({oMemWrite, oMemValidRequest, oMemAddress}), {8'd0, 2'b11, 22'h00010});
    chk("t1_mdata", 32'(oMemData), 32'h0000BEEF);
    cycle();
    chk("t1_done0", 32'({oDone0, oDone1, oAck0}), 32'b100);
    cycle();
    chk("t1_done0_pulse", 32'(oDone0), 32'd0);
    cycle();

    // Client 1 reads it back
    set_req(1, 0, 22'h00010, 16'h0000);
    cycle();
    iReq1 = 0;
    chk("t2_ack1", 32'({oAck0, oAck1}), 32'b01);
    cycle();
    chk("t2_done1", 32'({oDone0, oDone1}), 32'b01);
    chk("t2_rd1",   32'(oRdData1), 32'h0000BEEF);
    chk("t2_rd0",   32'(oRdData0), 32'h00000000);
    repeat (2) cycle();

    // Both clients held: strict alternation, one grant per 3 cycles
    set_req(0, 1, 22'h00001, 16'h1111);
    set_req(1, 1, 22'h00002, 16'h2222);
    for (int k = 0; k < 12; k++) begin
      cycle();
      chk("t3_ack0", 32'(oAck0), 32'((k % 6) == 0));
      chk("t3_ack1", 32'(oAck1), 32'((k % 6) == 3));
    end
    iReq0 = 0; iReq1 = 0;
    repeat (4) cycle();

    // Timeout: memory never answers
    stub_never = 1;
    saved_rd0 = oRdData0;
    set_req(0, 0, 22'h00003, 16'h0);
    cycle();
    iReq0 = 0;
    n = 1;
    while (n <= 40) begin
      cycle();
      if (oDone0) break;
      n++;
    end
    chk("t4_timeout_cycles", 32'(n), 32'(TIMEOUT));
    chk("t4_err_valid", 32'({oTimeoutErr, oMemValidRequest}), 32'b10);
    chk("t4_rd0_held", 32'(oRdData0), 32'(saved_rd0));
    repeat (5) cycle();
    chk("t4_err_sticky", 32'(oTimeoutErr), 32'd1);

    // Reset while a transaction is outstanding
    set_req(1, 0, 22'h00004, 16'h0);
    cycle();
    iReq1 = 0;
    repeat (2) cycle();
    iReset = 0;
    cycle();
    chk_all_zero("t5");
    iReset = 1; stub_never = 0;
    cycle();
    set_req(1, 1, 22'h00005, 16'h1234);
    cycle();
    iReq1 = 0;
    chk("t5_ack1", 32'(oAck1), 32'd1);
    n = 0;
    while (n < 10) begin
      cycle();
      n++;
      if (oDone1) break;
    end
    chk("t5_done_seen", 32'(oDone1), 32'd1);
    chk("t5_err_clear", 32'(oTimeoutErr), 32'd0);
    repeat (2) cycle();

    // Stray completion in IDLE, then completion held high through RECOVER
    saved_rd0 = oRdData0; saved_rd1 = oRdData1;
    force_mvr = 1;
    stub_update();
    repeat (3) cycle();
    chk("t6_idle_no_done", 32'({oDone0, oDone1, oMemValidRequest}), 32'd0);
    chk("t6_idle_rd_held", {oRdData0, oRdData1}, {saved_rd0, saved_rd1});
    set_req(0, 0, 22'h00006, 16'h0);
    cycle();
    iReq0 = 0;
    chk("t6_grant", 32'(oAck0), 32'd1);
    cycle();
    chk("t6_done", 32'(oDone0), 32'd1);
    saved_rd0 = oRdData0;
    cycle();
    chk("t6_recover_no_done", 32'({oDone0, oDone1}), 32'd0);
    chk("t6_recover_rd_held", 32'(oRdData0), 32'(saved_rd0));
    cycle();
    force_mvr = 0;
    cycle();

    // Randomized traffic against the model
    stray_en = 1;
    for (int i = 0; i < 4000; i++) begin
      if ((i % 300) == 0) begin
        case ($urandom_range(0, 2))
          0:       stub_delay_max = 0;
          1:       stub_delay_max = 3;
          default: stub_delay_max = 20;
        endcase
      end
      iReset  = ($urandom_range(0, 149) != 0);
      iReq0   = 1'($urandom_range(0, 1));
      iReq1   = 1'($urandom_range(0, 1));
      iWrite0 = 1'($urandom_range(0, 1));
      iWrite1 = 1'($urandom_range(0, 1));
      iAddr0  = 22'($urandom);
      iAddr1  = 22'($urandom);
      iData0  = 16'($urandom);
      iData1  = 16'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
